// File: rtl/l2_arbiter_if.sv
// Bundle of I-cache, D-cache and L2 register-slice signals seen by the L2 arbiter.
// The arbiter uses the slave view; the L1/L2 environment uses the master view.
interface l2_arbiter_if #(
  parameter int width = 256
);
  logic             icache_read;
  logic [31:0]      icache_address;
  logic [width-1:0] icache_rdata;
  logic             icache_resp;

  logic             dcache_read;
  logic             dcache_write;
  logic [31:0]      dcache_address;
  logic [width-1:0] dcache_wdata;
  logic [3:0]       dcache_byte_enable;
  logic [width-1:0] dcache_rdata;
  logic             dcache_resp;

  logic             L2cache_read;
  logic             L2cache_write;
  logic [31:0]      L2cache_address;
  logic [width-1:0] L2cache_wdata;
  logic [3:0]       L2cache_byte_enable;
  logic [width-1:0] L2cache_rdata;
  logic             L2cache_resp;

  modport slave (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable,
    input  L2cache_rdata, L2cache_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    output L2cache_read, L2cache_write, L2cache_address, L2cache_wdata, L2cache_byte_enable
  );

  modport master (
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_byte_enable,
    output L2cache_rdata, L2cache_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    input  L2cache_read, L2cache_write, L2cache_address, L2cache_wdata, L2cache_byte_enable
  );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 register slice between the I-cache and D-cache.
// A grant is held until L2cache_resp; outputs decode the registered state only.
module l2_arbiter #(
  parameter int width = 256
) (
  input  logic        clk,
  input  logic        rst,
  l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state, state_next;
  logic   last_grant, last_grant_next;
  logic   i_req, d_req;

  assign i_req = bus.icache_read;
  assign d_req = bus.dcache_read | bus.dcache_write;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    unique case (state)
      IDLE: begin
        // On a tie, the cache that was not granted last time wins.
        if (i_req && (!d_req || last_grant == GRANT_D)) begin
          state_next      = SERVE_I;
          last_grant_next = GRANT_I;
        end else if (d_req) begin
          state_next      = SERVE_D;
          last_grant_next = GRANT_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.L2cache_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset masks the outputs so an in-flight transaction never completes toward the L1.
  always_comb begin
    bus.L2cache_read        = 1'b0;
    bus.L2cache_write       = 1'b0;
    bus.L2cache_address     = '0;
    bus.L2cache_wdata       = '0;
    bus.L2cache_byte_enable = '0;
    bus.icache_resp         = 1'b0;
    bus.dcache_resp         = 1'b0;
    if (!rst) begin
      unique case (state)
        SERVE_I: begin
          bus.L2cache_read    = 1'b1;
          bus.L2cache_address = bus.icache_address;
          bus.icache_resp     = bus.L2cache_resp;
        end
        SERVE_D: begin
          bus.L2cache_read        = bus.dcache_read;
          bus.L2cache_write       = bus.dcache_write;
          bus.L2cache_address     = bus.dcache_address;
          bus.L2cache_wdata       = bus.dcache_wdata;
          bus.L2cache_byte_enable = bus.dcache_byte_enable;
          bus.dcache_resp         = bus.L2cache_resp;
        end
        default: ;
      endcase
    end
  end

  assign bus.icache_rdata = bus.L2cache_rdata;
  assign bus.dcache_rdata = bus.L2cache_rdata;

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter: width, default 256, L1/L2 line data width in bits.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 icache_read  in  1  I-cache line read request, held until icache_resp.
REQ-005 icache_address  in  32  I-cache line address.
REQ-006 icache_rdata  out  width  read data to I-cache.
REQ-007 icache_resp  out  1  single-cycle completion pulse to I-cache.
REQ-008 dcache_read / dcache_write  in  1 each  D-cache requests, mutually exclusive, held until dcache_resp.
REQ-009 dcache_address  in  32  D-cache line address.
REQ-010 dcache_wdata  in  width  D-cache write-back data.
REQ-011 dcache_byte_enable  in  4  D-cache byte enable.
REQ-012 dcache_rdata  out  width; dcache_resp  out  1  D-cache read data and completion pulse.
REQ-013 L2cache_read / L2cache_write  out  1 each  request to the L2 register slice.
REQ-014 L2cache_address  out  32; L2cache_wdata  out  width; L2cache_byte_enable  out  4  request payload to the L2 register slice.
REQ-015 L2cache_rdata  in  width; L2cache_resp  in  1  L2 read data and completion pulse.

Function
REQ-016 FSM states: IDLE, SERVE_I, SERVE_D; registered state plus a 1-bit last_grant register (I or D).
REQ-017 IDLE: with only icache_read set, next state is SERVE_I; with only dcache_read or dcache_write set, next state is SERVE_D; with none set, stay in IDLE.
REQ-018 IDLE with both caches requesting: grant the cache not equal to last_grant (round-robin).
REQ-019 last_grant updates to the granted cache on every IDLE->SERVE transition.
REQ-020 In IDLE, all L2cache_* outputs are 0.
REQ-021 In SERVE_I: L2cache_read=1, L2cache_write=0, L2cache_address=icache_address, L2cache_wdata=0, L2cache_byte_enable=0.
REQ-022 In SERVE_D: L2cache_read=dcache_read, L2cache_write=dcache_write, address/wdata/byte_enable from the dcache_* inputs.
REQ-023 Grant latency: a request sampled in IDLE at edge N drives L2cache_* outputs from cycle N+1; all outputs are combinational from the registered state.
REQ-024 The grant holds unconditionally until L2cache_resp, even if the granted requester deasserts (protocol violation; not aborted).
REQ-025 icache_resp = L2cache_resp while in SERVE_I, and dcache_resp = L2cache_resp while in SERVE_D, same cycle; otherwise 0.
REQ-026 icache_rdata and dcache_rdata both equal L2cache_rdata at all times.
REQ-027 L2cache_resp in SERVE_x returns the FSM to IDLE at the next edge; IDLE lasts at least one cycle so the L1 request drops before re-arbitration.
REQ-028 Back-to-back: after resp at cycle M, the earliest next grant drives L2cache_* outputs at cycle M+2.
REQ-029 L2cache_resp received in IDLE is ignored; no *_resp pulse and no state change.
REQ-030 A dcache request with both dcache_read and dcache_write set is illegal; the outputs pass through unchanged and behaviour is undefined.

Reset
REQ-031 rst=1 at a posedge forces state=IDLE and last_grant=I, so the first tie goes to D.
REQ-032 Reset takes priority over a simultaneous L2cache_resp and over any in-flight grant; the in-flight transaction is dropped without a *_resp pulse.
REQ-033 During and immediately after reset, all outputs except the rdata pass-throughs are 0.

Verification
REQ-034 Single I request: icache_read=1, addr 0x0000_0040, resp after 3 cycles with rdata 0xA5.. -> L2cache_read=1 and addr 0x40 one cycle after request; icache_resp=1 with rdata 0xA5..; dcache_resp=0.
REQ-035 Tie after reset: both caches request at once -> D granted first (SERVE_D); after D resp, I granted with an L2 request 2 cycles after resp; the next tie grants D again.
REQ-036 D write: dcache_write=1, addr 0x100, wdata pattern, byte_enable 0xF -> L2cache_write=1 with identical payload; L2cache_read=0; dcache_resp on L2cache_resp.
REQ-037 Held grant: in SERVE_I, icache_read drops for 2 cycles while dcache_read rises -> L2 still sees the I address until L2cache_resp; D is served afterwards.
REQ-038 Reset mid-operation: rst asserted in SERVE_D, same cycle as L2cache_resp -> next cycle IDLE, all L2cache_* outputs 0, no dcache_resp.
REQ-039 Stray resp: L2cache_resp=1 in IDLE -> no *_resp pulse and the state stays IDLE.
